// File: rtl/axis_dwc_hdr_n1_if.sv
// AXI-Stream bundle for the width down-converter; DUT ports use master/slave modports.
// M-side TSTRB is only part of the master modport when AXIS_DWC_MSTRB_EN is defined.
interface axis_dwc_hdr_n1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
`ifdef AXIS_DWC_MSTRB_EN
    output tstrb,
`endif
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/axis_dwc_hdr_n1.sv
// AXI-Stream width down-converter with optional per-packet TUSER header beat.
// Define AXIS_DWC_MSTRB_EN to store lane strobes and drive M-side TSTRB.
module axis_dwc_hdr_n1 #(
  parameter int M_DATA_WIDTH = 32,
  parameter int RATIO        = 2,
  parameter int USER_WIDTH   = 32,
  parameter int HDR_EN       = 1
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESET,
  axis_dwc_hdr_n1_if.slave    S_AXIS,
  axis_dwc_hdr_n1_if.master   M_AXIS
);
  localparam int WW = RATIO * M_DATA_WIDTH;
  localparam int LS = M_DATA_WIDTH / 8;
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {ST_HDR, ST_DATA} state_t;

  state_t                  state_q;
  logic                    full_q;
  logic                    sop_q;
  logic                    wordLast_q;
  logic [LW-1:0]           lane_q;
  logic [LW-1:0]           lastLane_q;
  logic [WW-1:0]           data_q;
  logic [M_DATA_WIDTH-1:0] tdata_q;
  logic                    tlast_q;
`ifdef AXIS_DWC_MSTRB_EN
  logic [WW/8-1:0]         strb_q;
  logic [LS-1:0]           tstrb_q;
`endif

  logic                    mXfr;
  logic                    finalLane;
  logic                    sTready;
  logic                    load;
  logic                    sop_d;
  logic                    hdr_d;
  logic [LW-1:0]           lane_d;
  logic [LW-1:0]           inLastLane;
  logic [M_DATA_WIDTH-1:0] userExt;

  // Highest lane carrying any strobe on a TLAST word; lane 0 always survives.
  always_comb begin
    inLastLane = LW'(RATIO - 1);
    if (S_AXIS.tlast) begin
      inLastLane = '0;
      for (int k = 1; k < RATIO; k++) begin
        if (|S_AXIS.tstrb[k*LS +: LS]) inLastLane = LW'(k);
      end
    end
  end

  assign finalLane = (state_q == ST_DATA) && (lane_q == lastLane_q);
  assign mXfr      = full_q && M_AXIS.tready;
  assign sTready   = !AXIS_ARESET && (!full_q || (mXfr && finalLane));
  assign load      = S_AXIS.tvalid && sTready;
  assign sop_d     = (mXfr && finalLane) ? wordLast_q : sop_q;
  assign hdr_d     = (HDR_EN != 0) && sop_d;
  assign lane_d    = lane_q + LW'(1);
  assign userExt   = M_DATA_WIDTH'(S_AXIS.tuser);

  // Output beat is registered: each transition precomputes the next beat to present.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      full_q  <= 1'b0;
      sop_q   <= 1'b1;
      lane_q  <= '0;
      state_q <= ST_DATA;
      tdata_q <= '0;
      tlast_q <= 1'b0;
`ifdef AXIS_DWC_MSTRB_EN
      tstrb_q <= '0;
`endif
    end else if (load) begin
      full_q     <= 1'b1;
      sop_q      <= sop_d;
      lane_q     <= '0;
      data_q     <= S_AXIS.tdata;
      wordLast_q <= S_AXIS.tlast;
      lastLane_q <= inLastLane;
`ifdef AXIS_DWC_MSTRB_EN
      strb_q     <= S_AXIS.tstrb;
`endif
      if (hdr_d) begin
        state_q <= ST_HDR;
        tdata_q <= userExt;
        tlast_q <= 1'b0;
`ifdef AXIS_DWC_MSTRB_EN
        tstrb_q <= '1;
`endif
      end else begin
        state_q <= ST_DATA;
        tdata_q <= S_AXIS.tdata[M_DATA_WIDTH-1:0];
        tlast_q <= S_AXIS.tlast && (inLastLane == '0);
`ifdef AXIS_DWC_MSTRB_EN
        tstrb_q <= S_AXIS.tstrb[LS-1:0];
`endif
      end
    end else if (mXfr) begin
      if (state_q == ST_HDR) begin
        state_q <= ST_DATA;
        sop_q   <= 1'b0;
        lane_q  <= '0;
        tdata_q <= data_q[M_DATA_WIDTH-1:0];
        tlast_q <= wordLast_q && (lastLane_q == '0);
`ifdef AXIS_DWC_MSTRB_EN
        tstrb_q <= strb_q[LS-1:0];
`endif
      end else if (!finalLane) begin
        lane_q  <= lane_d;
        tdata_q <= data_q[int'(lane_d)*M_DATA_WIDTH +: M_DATA_WIDTH];
        tlast_q <= wordLast_q && (lane_d == lastLane_q);
`ifdef AXIS_DWC_MSTRB_EN
        tstrb_q <= strb_q[int'(lane_d)*LS +: LS];
`endif
      end else begin
        full_q  <= 1'b0;
        sop_q   <= wordLast_q;
        tlast_q <= 1'b0;
      end
    end
  end

  assign S_AXIS.tready = sTready;
  assign M_AXIS.tvalid = full_q;
  assign M_AXIS.tdata  = tdata_q;
  assign M_AXIS.tlast  = tlast_q;
`ifdef AXIS_DWC_MSTRB_EN
  assign M_AXIS.tstrb  = tstrb_q;
`endif
endmodule

// File: tb/tb_axis_dwc_hdr_n1.sv
// Directed bench for axis_dwc_hdr_n1: a RATIO=2 header build and a RATIO=4 headerless build.
module tb_axis_dwc_hdr_n1;
  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   failCount = 0;
  logic readyFixed = 1'b1;
  logic readyRandom = 1'b0;
  logic randReady;
  int   run = 0;
  int   maxRun = 0;
  logic stallPrev = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t gotQ[$];
  beat_t expQ[$];
  beat_t stallBeat;

  always #5 clk = ~clk;

  axis_dwc_hdr_n1_if #(.DATA_WIDTH(64),  .USER_WIDTH(32)) sIf ();
  axis_dwc_hdr_n1_if #(.DATA_WIDTH(32),  .USER_WIDTH(1))  mIf ();
  axis_dwc_hdr_n1_if #(.DATA_WIDTH(128), .USER_WIDTH(32)) s4If ();
  axis_dwc_hdr_n1_if #(.DATA_WIDTH(32),  .USER_WIDTH(1))  m4If ();

  axis_dwc_hdr_n1 #(.M_DATA_WIDTH(32), .RATIO(2), .USER_WIDTH(32), .HDR_EN(1)) dut (
    .AXIS_ACLK   (clk),
    .AXIS_ARESET (reset),
    .S_AXIS      (sIf.slave),
    .M_AXIS      (mIf.master)
  );

  axis_dwc_hdr_n1 #(.M_DATA_WIDTH(32), .RATIO(4), .USER_WIDTH(32), .HDR_EN(0)) dut4 (
    .AXIS_ACLK   (clk),
    .AXIS_ARESET (reset),
    .S_AXIS      (s4If.slave),
    .M_AXIS      (m4If.master)
  );

  assign mIf.tready  = readyRandom ? randReady : readyFixed;
  assign m4If.tready = 1'b1;
  assign mIf.tuser   = '0;
  assign m4If.tuser  = '0;
`ifndef AXIS_DWC_MSTRB_EN
  assign mIf.tstrb   = '0;
  assign m4If.tstrb  = '0;
`endif

  always @(posedge clk) begin
    #1;
    randReady = 1'($urandom % 2);
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Narrow-side monitor: records transfers, checks hold-while-stalled, tracks valid run length.
  always @(negedge clk) begin
    if (!reset) begin
      if (stallPrev)
        checkOutput("stall hold", {mIf.tvalid, mIf.tlast, mIf.tdata}, {1'b1, stallBeat.last, stallBeat.data});
      if (mIf.tvalid && mIf.tready) gotQ.push_back({mIf.tdata, mIf.tlast});
      stallPrev = mIf.tvalid && !mIf.tready;
      stallBeat = {mIf.tdata, mIf.tlast};
      run = mIf.tvalid ? run + 1 : 0;
      if (run > maxRun) maxRun = run;
    end else begin
      stallPrev = 1'b0;
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic [7:0] strb,
                               input logic last, input logic [31:0] user);
    logic acc = 1'b0;
    int   n = 0;
    sIf.tvalid = 1'b1;
    sIf.tdata  = data;
    sIf.tstrb  = strb;
    sIf.tlast  = last;
    sIf.tuser  = user;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = sIf.tready;
      tick();
      n++;
    end
    sIf.tvalid = 1'b0;
    if (!acc) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic expBeat(input logic [31:0] d, input logic l);
    expQ.push_back({d, l});
  endtask

  task automatic drainAndCompare(input string tag);
    int n = 0;
    while ((gotQ.size() != expQ.size() || mIf.tvalid) && n < 300) begin
      tick();
      n++;
    end
    checkOutput({tag, " beat count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("%s beat %0d", tag, i), gotQ[i], expQ[i]);
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    reset = 1'b1;
    sIf.tvalid = 1'b0; sIf.tdata = '0; sIf.tstrb = '0; sIf.tlast = 1'b0; sIf.tuser = '0;
    s4If.tvalid = 1'b0; s4If.tdata = '0; s4If.tstrb = '0; s4If.tlast = 1'b0; s4If.tuser = '0;
    tick();
    tick();
    checkOutput("reset tvalid", mIf.tvalid, 0);
    checkOutput("reset tlast", mIf.tlast, 0);
    checkOutput("reset tdata", mIf.tdata, 0);
    checkOutput("reset s_tready", sIf.tready, 0);
    checkOutput("reset tvalid r4", m4If.tvalid, 0);
    reset = 1'b0;
    #1;
    checkOutput("idle s_tready", sIf.tready, 1);

    // Two-word packet with header
    applyStimulus(64'h11111111_00000000, 8'hFF, 1'b0, 32'hA5A5A5A5);
    checkOutput("hdr latency", {mIf.tvalid, mIf.tdata}, {1'b1, 32'hA5A5A5A5});
    applyStimulus(64'h33333333_22222222, 8'hFF, 1'b1, 32'hDEADBEEF);
    expBeat(32'hA5A5A5A5, 0); expBeat(32'h00000000, 0); expBeat(32'h11111111, 0);
    expBeat(32'h22222222, 0); expBeat(32'h33333333, 1);
    drainAndCompare("t1");

    // Trailing-lane drop: strobes only in lane 0, then no strobes at all
    applyStimulus(64'hBBBBBBBB_AAAAAAAA, 8'h0F, 1'b1, 32'h12345678);
    applyStimulus(64'hDDDDDDDD_CCCCCCCC, 8'h00, 1'b1, 32'h00000009);
    expBeat(32'h12345678, 0); expBeat(32'hAAAAAAAA, 1);
    expBeat(32'h00000009, 0); expBeat(32'hCCCCCCCC, 1);
    drainAndCompare("t2");

    // Back-to-back four-word packet with ready held high
    maxRun = 0;
    for (int i = 0; i < 4; i++)
      applyStimulus({32'h11 + 32'(2*i), 32'h10 + 32'(2*i)}, 8'hFF, 1'(i == 3), 32'h0000C0DE);
    expBeat(32'h0000C0DE, 0);
    for (int i = 0; i < 8; i++) expBeat(32'h10 + 32'(i), 1'(i == 7));
    drainAndCompare("t3");
    checkOutput("no-bubble run", maxRun, 9);

    // Random backpressure across two packets
    readyRandom = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus({32'h41 + 32'(2*i), 32'h40 + 32'(2*i)}, 8'hFF, 1'(i == 2), 32'h00000077);
    applyStimulus(64'h00000051_00000050, 8'hF0, 1'b1, 32'h00000088);
    expBeat(32'h00000077, 0);
    for (int i = 0; i < 6; i++) expBeat(32'h40 + 32'(i), 1'(i == 5));
    expBeat(32'h00000088, 0); expBeat(32'h00000050, 0); expBeat(32'h00000051, 1);
    drainAndCompare("t4");
    readyRandom = 1'b0;

    // Reset while lane 1 is presented; next packet restarts with its own header
    applyStimulus(64'h00000061_00000060, 8'hFF, 1'b0, 32'h000000AA);
    tick();
    tick();
    checkOutput("t5 lane1 shown", mIf.tdata, 32'h00000061);
    reset = 1'b1;
    tick();
    checkOutput("t5 tvalid after reset", mIf.tvalid, 0);
    checkOutput("t5 s_tready in reset", sIf.tready, 0);
    reset = 1'b0;
    applyStimulus(64'h00000071_00000070, 8'hFF, 1'b1, 32'h000000BB);
    expBeat(32'h000000AA, 0); expBeat(32'h00000060, 0);
    expBeat(32'h000000BB, 0); expBeat(32'h00000070, 0); expBeat(32'h00000071, 1);
    drainAndCompare("t5");

    // RATIO=4 headerless: strobes up to lane 2 on the last word
    begin
      logic acc = 1'b0;
      int   n = 0;
      s4If.tvalid = 1'b1;
      s4If.tdata  = 128'h44444444_33333333_22222222_11111111;
      s4If.tstrb  = 16'h0F00;
      s4If.tlast  = 1'b1;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = s4If.tready;
        tick();
        n++;
      end
      s4If.tvalid = 1'b0;
      checkOutput("t6 accepted", acc, 1);
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("t6 lane %0d", i), {m4If.tvalid, m4If.tlast, m4If.tdata},
                    {1'b1, 1'(i == 2), 32'h11111111 * 32'(i + 1)});
        tick();
      end
      checkOutput("t6 idle after", m4If.tvalid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
